alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 4, operand/result width in bits; legal range 2..32.
REQ-002 Parameter OPCODE_LENGTH, default 3, opcode width; only value 3 supported.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 src_a  input  DATA_WIDTH  operand A, sampled only on accept.
REQ-006 src_b  input  DATA_WIDTH  operand B, sampled only on accept.
REQ-007 operation  input  OPCODE_LENGTH  opcode, sampled only on accept.
REQ-008 in_valid  input  1  request present.
REQ-009 in_ready  output  1  block can accept request this cycle.
REQ-010 alu_result  output  DATA_WIDTH  registered result.
REQ-011 zero_flag  output  1  alu_result == 0.
REQ-012 carry_flag  output  1  carry/borrow/product-overflow indicator.
REQ-013 negative_flag  output  1  alu_result MSB.
REQ-014 overflow_flag  output  1  signed overflow.
REQ-015 out_valid  output  1  result and flags valid.
REQ-016 out_ready  input  1  consumer takes result this cycle.

Function
REQ-017 Accept SHALL occur on a rising edge where in_valid && in_ready; operands and opcode are latched there, later input changes have no effect.
REQ-018 Opcodes SHALL be: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 SLT (1 if signed A<B else 0), 110 SLL (A << B[log2(DATA_WIDTH)-1:0]), 111 MUL (low DATA_WIDTH bits of unsigned A*B).
REQ-019 All arithmetic SHALL be modulo 2^DATA_WIDTH; results truncated, never widened.
REQ-020 FSM states SHALL be IDLE, MUL_BUSY, DONE.
REQ-021 IDLE: in_ready=1; accept of opcodes 000-110 -> result/flags loaded on accept edge, go DONE; accept of 111 -> go MUL_BUSY.
REQ-022 MUL_BUSY: iterative shift-add, one multiplier bit per cycle, exactly DATA_WIDTH cycles; the DATA_WIDTH-th edge after accept loads result/flags and enters DONE; in_ready=0 throughout.
REQ-023 DONE: out_valid=1; if out_ready=0, alu_result, all flags and out_valid SHALL hold stable.
REQ-024 DONE with out_ready=1: in_ready=1; with in_valid=1 the new request is accepted on the same edge (back-to-back, next state per REQ-021 rules); with in_valid=0 go IDLE, out_valid=0.
REQ-025 Latency: non-MUL out_valid rises 1 edge after accept; MUL rises DATA_WIDTH edges after accept.
REQ-026 ADD: carry_flag = carry-out; overflow_flag = signed overflow.
REQ-027 SUB: carry_flag = borrow (unsigned A<B); overflow_flag = signed overflow.
REQ-028 MUL: carry_flag = 1 iff discarded high product bits non-zero; overflow_flag=0.
REQ-029 AND/OR/XOR/SLT/SLL: carry_flag=0, overflow_flag=0.
REQ-030 zero_flag and negative_flag SHALL derive from the loaded alu_result for every opcode.
REQ-031 in_valid while in_ready=0 SHALL be ignored, no state change.

Reset
REQ-032 rst_n low SHALL immediately force state IDLE, alu_result=0, all flags=0, out_valid=0, internal multiply registers=0, regardless of clk.
REQ-033 in_ready SHALL be 1 while in IDLE, including during and after reset.
REQ-034 Reset during MUL_BUSY or DONE SHALL abort the operation; no result is emitted after release.
REQ-035 First accept possible on first rising edge with rst_n high.

Verification (DATA_WIDTH=4)
REQ-036 ADD A=7,B=9 -> next edge out_valid=1, result=0, zero=1, carry=1, overflow=0, negative=0.
REQ-037 SUB A=1,B=2 -> result=4'hF, negative=1, carry=1, overflow=0; ADD A=7,B=1 -> result=8, overflow=1, negative=1.
REQ-038 MUL A=3,B=5 -> in_ready=0 for 4 cycles, out_valid on 4th edge, result=15, carry=0; MUL A=6,B=3 -> result=2, carry=1.
REQ-039 Backpressure: out_ready=0 for 3 cycles in DONE -> outputs unchanged, in_ready=0; then out_ready=1 with in_valid=1 (AND 12,10) -> accepted same edge, next result=8.
REQ-040 rst_n low 2 cycles into MUL 15*15 -> outputs zero immediately, out_valid=0; after release in_ready=1, no stale result appears.
REQ-041 SLL A=3,B=2 -> result=12, carry=0; SLT A=-1(4'hF),B=1 -> result=1.

Source files
------------

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Sequential ALU with a valid/ready request port and a
//            valid/ready result port. ADD/SUB/AND/OR/XOR/SLT/SLL complete on
//            the accept edge. MUL runs as an iterative shift-add over
//            DATA_WIDTH cycles. Results and flags are registered and held
//            stable while the consumer stalls.
// Ports    : clk, rst_n              - clock, async active-low reset
//            src_a, src_b, operation - request operands/opcode (sampled on accept)
//            in_valid / in_ready     - request handshake
//            alu_result, *_flag      - registered result and status flags
//            out_valid / out_ready   - result handshake
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int DATA_WIDTH    = 4,
  parameter int OPCODE_LENGTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    src_a,
  input  logic [DATA_WIDTH-1:0]    src_b,
  input  logic [OPCODE_LENGTH-1:0] operation,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_WIDTH-1:0]    alu_result,
  output logic                     zero_flag,
  output logic                     carry_flag,
  output logic                     negative_flag,
  output logic                     overflow_flag,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int W  = DATA_WIDTH;
  localparam int SW = $clog2(DATA_WIDTH);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_MUL_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE     = 2'd2;

  localparam logic [OPCODE_LENGTH-1:0] OP_ADD = 3'b000;
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB = 3'b001;
  localparam logic [OPCODE_LENGTH-1:0] OP_AND = 3'b010;
  localparam logic [OPCODE_LENGTH-1:0] OP_OR  = 3'b011;
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR = 3'b100;
  localparam logic [OPCODE_LENGTH-1:0] OP_SLT = 3'b101;
  localparam logic [OPCODE_LENGTH-1:0] OP_SLL = 3'b110;
  localparam logic [OPCODE_LENGTH-1:0] OP_MUL = 3'b111;

  // Bit counter value on the final multiply step.
  localparam logic [SW-1:0] CNT_LAST = SW'(W - 1);

  logic [1:0]     state_q, state_d;
  logic           w_accept;
  logic           w_is_mul;

  // Single-cycle datapath
  logic [W:0]     w_sum;
  logic [W:0]     w_diff;
  logic [W-1:0]   w_res;
  logic           w_carry;
  logic           w_ovf;

  // Iterative multiplier
  logic [2*W-1:0] mcand_q;
  logic [W-1:0]   mplier_q;
  logic [2*W-1:0] acc_q;
  logic [SW-1:0]  cnt_q;
  logic [2*W-1:0] w_acc_next;
  logic           w_mul_last;

  // Registered outputs
  logic [W-1:0]   result_q;
  logic           zero_q;
  logic           carry_q;
  logic           neg_q;
  logic           ovf_q;

  assign w_accept   = in_valid && in_ready;
  assign w_is_mul   = (operation == OP_MUL);
  assign w_mul_last = (state_q == ST_MUL_BUSY) && (cnt_q == CNT_LAST);

  // One partial product per cycle; the multiplicand shifts left as the
  // multiplier shifts right, so only bit 0 of the multiplier is inspected.
  assign w_acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          state_d = w_is_mul ? ST_MUL_BUSY : ST_DONE;
        end
      end
      ST_MUL_BUSY: begin
        if (w_mul_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Back-to-back: a new request can be taken as the result is consumed.
        if (w_accept) begin
          state_d = w_is_mul ? ST_MUL_BUSY : ST_DONE;
        end else if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Single-cycle operations, evaluated on the live request inputs so the
  // result can be captured on the accept edge.
  // --------------------------------------------------------------------------
  always_comb begin
    w_sum   = {1'b0, src_a} + {1'b0, src_b};
    w_diff  = {1'b0, src_a} - {1'b0, src_b};
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (operation)
      OP_ADD: begin
        w_res   = w_sum[W-1:0];
        w_carry = w_sum[W];
        w_ovf   = (src_a[W-1] == src_b[W-1]) && (w_sum[W-1] != src_a[W-1]);
      end
      OP_SUB: begin
        w_res   = w_diff[W-1:0];
        w_carry = w_diff[W];  // borrow out of the zero-extended subtraction
        w_ovf   = (src_a[W-1] != src_b[W-1]) && (w_diff[W-1] != src_a[W-1]);
      end
      OP_AND: w_res = src_a & src_b;
      OP_OR:  w_res = src_a | src_b;
      OP_XOR: w_res = src_a ^ src_b;
      OP_SLT: w_res = {{(W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_SLL: w_res = src_a << src_b[SW-1:0];
      default: begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (w_accept) begin
      if (w_is_mul) begin
        mcand_q  <= {{W{1'b0}}, src_a};
        mplier_q <= src_b;
        acc_q    <= '0;
        cnt_q    <= '0;
      end else begin
        result_q <= w_res;
        zero_q   <= (w_res == '0);
        carry_q  <= w_carry;
        neg_q    <= w_res[W-1];
        ovf_q    <= w_ovf;
      end
    end else if (state_q == ST_MUL_BUSY) begin
      acc_q    <= w_acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + SW'(1);
      // The last step folds in the final partial product and publishes it.
      if (w_mul_last) begin
        result_q <= w_acc_next[W-1:0];
        zero_q   <= (w_acc_next[W-1:0] == '0);
        carry_q  <= |w_acc_next[2*W-1:W];
        neg_q    <= w_acc_next[W-1];
        ovf_q    <= 1'b0;
      end
    end
  end

  assign alu_result    = result_q;
  assign zero_flag     = zero_q;
  assign carry_flag    = carry_q;
  assign negative_flag = neg_q;
  assign overflow_flag = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Self-checking bench for alu_seq (DATA_WIDTH=4). It runs directed
//            vectors, reset aborts and a randomized request stream, and
//            compares every result against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic [2:0]   operation;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] alu_result;
  logic         zero_flag;
  logic         carry_flag;
  logic         negative_flag;
  logic         overflow_flag;
  logic         out_valid;
  logic         out_ready;

  int           n_checks;
  int           n_fail;
  logic [W-1:0] exp_res;
  logic [3:0]   exp_flags;  // {zero, carry, negative, overflow}

  alu_seq #(
    .DATA_WIDTH    (W),
    .OPCODE_LENGTH (3)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .src_a         (src_a),
    .src_b         (src_b),
    .operation     (operation),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .alu_result    (alu_result),
    .zero_flag     (zero_flag),
    .carry_flag    (carry_flag),
    .negative_flag (negative_flag),
    .overflow_flag (overflow_flag),
    .out_valid     (out_valid),
    .out_ready     (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the opcode definitions.
  // Returns {result, zero, carry, negative, overflow}.
  function automatic logic [W+3:0] model(input int a, input int b, input int op);
    int m, sa, sb, full, r;
    bit c, v;
    m  = 1 << W;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    c  = 1'b0;
    v  = 1'b0;
    case (op)
      0: begin
        full = a + b;
        c    = (full >= m);
        v    = (sa + sb >= m / 2) || (sa + sb < -(m / 2));
      end
      1: begin
        full = a - b;
        c    = (a < b);
        v    = (sa - sb >= m / 2) || (sa - sb < -(m / 2));
      end
      2: full = a & b;
      3: full = a | b;
      4: full = a ^ b;
      5: full = (sa < sb) ? 1 : 0;
      6: full = a << (b % W);
      default: begin
        full = a * b;
        c    = (full >= m);
      end
    endcase
    r = full & (m - 1);
    return {W'(r), (r == 0), c, (r >= m / 2), v};
  endfunction

  // Inputs that must be ignored: consumer stalls, request lines carry junk.
  task automatic noise();
    out_ready = 1'b0;
    in_valid  = 1'($urandom % 2);
    src_a     = W'($urandom);
    src_b     = W'($urandom);
    operation = 3'($urandom);
  endtask

  task automatic check_done(input string tag);
    check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_in_ready"},  32'(in_ready),  32'd0);
    check_eq({tag, "_result"},    32'(alu_result), 32'(exp_res));
    check_eq({tag, "_flags"},
             32'({zero_flag, carry_flag, negative_flag, overflow_flag}), 32'(exp_flags));
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check_eq({tag, "_result"},    32'(alu_result), 32'd0);
    check_eq({tag, "_flags"},
             32'({zero_flag, carry_flag, negative_flag, overflow_flag}), 32'd0);
  endtask

  // Issue one request (back-to-back if the DUT is holding a result), follow
  // it through the busy period and check the loaded result.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    logic [W+3:0] e;
    e         = model(int'(a), int'(b), int'(op));
    exp_res   = e[W+3:4];
    exp_flags = e[3:0];
    src_a     = a;
    src_b     = b;
    operation = op;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check_eq("accept_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    noise();
    if (op == 3'b111) begin
      for (int k = 0; k < W; k++) begin
        #1;
        check_eq("mul_busy_out_valid", 32'(out_valid), 32'd0);
        check_eq("mul_busy_in_ready",  32'(in_ready),  32'd0);
        @(negedge clk);
        noise();
      end
    end
    #1;
    check_done("done");
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      noise();
      #1;
      check_done("hold");
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    #1;
    check_eq("release_out_valid", 32'(out_valid), 32'd0);
    check_eq("release_in_ready",  32'(in_ready),  32'd1);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    clk       = 1'b0;
    rst_n     = 1'b0;
    src_a     = '0;
    src_b     = '0;
    operation = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_res   = '0;
    exp_flags = '0;

    #2;
    check_reset_state("por");
    repeat (2) @(negedge clk);
    #1;
    check_reset_state("reset_held");
    rst_n = 1'b1;

    // Directed vectors; the first request lands on the first edge after release.
    send(4'd7, 4'd9, 3'b000);
    release_result();
    send(4'd1, 4'd2, 3'b001);
    send(4'd7, 4'd1, 3'b000);
    send(4'd3, 4'd5, 3'b111);
    send(4'd6, 4'd3, 3'b111);
    hold(3);
    send(4'd12, 4'd10, 3'b010);
    release_result();
    send(4'd3, 4'd2, 3'b110);
    send(4'hF, 4'd1, 3'b101);
    release_result();

    // Reset two cycles into a multiply: nothing may surface afterwards.
    src_a     = 4'd15;
    src_b     = 4'd15;
    operation = 3'b111;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    noise();
    @(negedge clk);
    noise();
    #1;
    check_eq("abort_mul_busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_state("abort_mul_async");
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    for (int k = 0; k < W + 2; k++) begin
      out_ready = 1'($urandom % 2);
      @(negedge clk);
      #1;
      check_reset_state("abort_mul_after");
    end

    // Reset while a result is being held.
    send(4'd7, 4'd1, 3'b000);
    rst_n = 1'b0;
    #1;
    check_reset_state("abort_done_async");
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    check_reset_state("abort_done_after");

    // Randomized stream with random stalls and mixed back-to-back / idle gaps.
    for (int i = 0; i < 300; i++) begin
      send(W'($urandom), W'($urandom), 3'($urandom));
      hold(int'($urandom_range(0, 3)));
      if (($urandom % 2) == 0) begin
        release_result();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
